// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt/trap controller:
// interrupt codes, mip bit positions, FSM states and cause encoders.
package irq_ctrl_pkg;

  // Interrupt cause codes (low bits of mcause when bit 31 is set)
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  // Bit positions of the pending flags inside mip
  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    HANDLER = 2'd2
  } irq_state_t;

  // Highest-priority active interrupt code: MEI > MSI > MTI.
  // Only meaningful when at least one of the three bits is set.
  function automatic logic [4:0] irq_code(input logic [31:0] act);
    logic [4:0] code;
    if (act[MIP_MEIP])      code = IRQ_MEI;
    else if (act[MIP_MSIP]) code = IRQ_MSI;
    else                    code = IRQ_MTI;
    return code;
  endfunction

  // mcause word for an interrupt (bit 31 set)
  function automatic logic [31:0] irq_cause_word(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

  // mcause word for a synchronous exception (bit 31 clear)
  function automatic logic [31:0] exc_cause_word(input logic [4:0] code);
    return {27'b0, code};
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_ff.sv
// Multi-bit, multi-stage flip-flop synchronizer with asynchronous clear.
// Each bit is an independent level synchronizer; STAGES must be >= 2.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the raw input into stage 0 and every stage into the next one
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d_i};
  end

  // Synchronizer chain, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt and trap controller. Synchronizes the platform
// interrupt lines into mip, arbitrates interrupts against synchronous
// exceptions and issues a one-cycle trap request per trap.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_EXT     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               timer_irq,
  input  logic               soft_irq,
  input  logic [31:0]        mie,
  input  logic               irq_en,
  input  logic               boundary,
  input  logic               exc_valid,
  input  logic [4:0]         exc_cause,
  input  logic               trap_finish,
  output logic [31:0]        mip,
  output logic [31:0]        trap_cause,
  output logic               trap_pending,
  output logic               wake
);

  localparam int SW = NUM_EXT + 2;

  logic [SW-1:0] sync_in;
  logic [SW-1:0] sync_out;

  logic [31:0]   mip_d, mip_q;
  logic [31:0]   irq_act;
  logic          take_irq;

  irq_state_t    state_d, state_q;
  logic [31:0]   trap_cause_d, trap_cause_q;
  logic          trap_pending_d, trap_pending_q;

  // Layout: [NUM_EXT-1:0] external, [NUM_EXT] timer, [NUM_EXT+1] software
  assign sync_in = {soft_irq, timer_irq, ext_irq};

  sync_ff #(
    .WIDTH  (SW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sync_in),
    .q_o (sync_out)
  );

  // Build the pending word from the synchronized lines; no latching
  always_comb begin
    mip_d           = '0;
    mip_d[MIP_MEIP] = |sync_out[NUM_EXT-1:0];
    mip_d[MIP_MTIP] = sync_out[NUM_EXT];
    mip_d[MIP_MSIP] = sync_out[NUM_EXT+1];
  end

  // mip register, refreshed every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mip_q <= '0;
    else     mip_q <= mip_d;
  end

  assign irq_act  = mip_q & mie;
  assign wake     = |irq_act;
  assign take_irq = boundary & irq_en & (|irq_act);

  // Next-state and cause selection; exceptions beat interrupts and
  // interrupts are only considered in IDLE
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d      = TRAP;
          trap_cause_d = exc_cause_word(exc_cause);
        end else if (take_irq) begin
          state_d      = TRAP;
          trap_cause_d = irq_cause_word(irq_code(irq_act));
        end
      end
      TRAP: begin
        state_d = HANDLER;
      end
      HANDLER: begin
        if (exc_valid) begin
          state_d      = TRAP;
          trap_cause_d = exc_cause_word(exc_cause);
        end else if (trap_finish) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    trap_pending_d = (state_d == TRAP);
  end

  // Trap FSM with registered trap_pending and trap_cause outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      trap_cause_q   <= '0;
      trap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      trap_cause_q   <= trap_cause_d;
      trap_pending_q <= trap_pending_d;
    end
  end

  assign mip          = mip_q;
  assign trap_cause   = trap_cause_q;
  assign trap_pending = trap_pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, exception, priority, masking,
// collision and reset-during-trap scenarios with hand-computed values.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  ext_irq;
  logic        timer_irq;
  logic        soft_irq;
  logic [31:0] mie;
  logic        irq_en;
  logic        boundary;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic        trap_finish;
  logic [31:0] mip;
  logic [31:0] trap_cause;
  logic        trap_pending;
  logic        wake;

  int n_chk  = 0;
  int n_pass = 0;

  irq_ctrl #(
    .NUM_EXT     (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ext_irq      (ext_irq),
    .timer_irq    (timer_irq),
    .soft_irq     (soft_irq),
    .mie          (mie),
    .irq_en       (irq_en),
    .boundary     (boundary),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .trap_finish  (trap_finish),
    .mip          (mip),
    .trap_cause   (trap_cause),
    .trap_pending (trap_pending),
    .wake         (wake)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From the trap_pending cycle: move into HANDLER, then mret back to IDLE
  task automatic finish_trap(input string tag);
    boundary = 1'b0;
    step();
    chk({tag, "_handler"}, 32'(dut.state_q), 32'(HANDLER));
    trap_finish = 1'b1;
    step();
    trap_finish = 1'b0;
    chk({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    // ---- Reset with every input high ----
    rst = 1'b1; ext_irq = 4'hF; timer_irq = 1'b1; soft_irq = 1'b1;
    mie = 32'hFFFF_FFFF; irq_en = 1'b1; boundary = 1'b1;
    exc_valid = 1'b1; exc_cause = 5'h1F; trap_finish = 1'b1;
    repeat (3) step();
    chk("rst_mip",   mip,                 32'h0);
    chk("rst_pend",  32'(trap_pending),   32'h0);
    chk("rst_cause", trap_cause,          32'h0);
    chk("rst_wake",  32'(wake),           32'h0);

    // Release reset with lines still high; control inputs quiet
    exc_valid = 1'b0; exc_cause = 5'd0; trap_finish = 1'b0;
    boundary = 1'b0; irq_en = 1'b0; mie = 32'h0;
    rst = 1'b0;
    step();
    chk("rel_mip_e1", mip, 32'h0);
    step();
    chk("rel_mip_e2", mip, 32'h0);
    step();
    chk("rel_mip_e3", mip, 32'h0000_0888);

    // ---- Single exception from IDLE ----
    ext_irq = 4'h0; timer_irq = 1'b0; soft_irq = 1'b0;
    repeat (3) step();
    chk("exc_mip_clr", mip, 32'h0);
    exc_valid = 1'b1; exc_cause = 5'd2;
    step();
    exc_valid = 1'b0;
    chk("exc_pend",  32'(trap_pending), 32'h1);
    chk("exc_cause", trap_cause,        32'h0000_0002);
    step();
    chk("exc_pend_off", 32'(trap_pending), 32'h0);
    chk("exc_handler",  32'(dut.state_q),  32'(HANDLER));
    trap_finish = 1'b1;
    step();
    trap_finish = 1'b0;
    chk("exc_idle",  32'(dut.state_q), 32'(IDLE));
    chk("exc_hold",  trap_cause,       32'h0000_0002);

    // ---- exc_valid held into TRAP is ignored; nested exception wins over mret ----
    exc_valid = 1'b1; exc_cause = 5'd5;
    step();
    chk("trp_pend",  32'(trap_pending), 32'h1);
    chk("trp_cause", trap_cause,        32'h0000_0005);
    exc_cause = 5'd6;
    step();
    chk("trp_ign_pend",  32'(trap_pending), 32'h0);
    chk("trp_ign_cause", trap_cause,        32'h0000_0005);
    exc_cause = 5'd7; trap_finish = 1'b1;
    step();
    exc_valid = 1'b0; trap_finish = 1'b0;
    chk("nest_pend",  32'(trap_pending), 32'h1);
    chk("nest_cause", trap_cause,        32'h0000_0007);
    finish_trap("nest");

    // ---- Priority: MEI > MSI > MTI ----
    ext_irq = 4'h1; timer_irq = 1'b1; soft_irq = 1'b1;
    mie = 32'h0000_0888; irq_en = 1'b1;
    repeat (3) step();
    chk("pri_mip",  mip,          32'h0000_0888);
    chk("pri_wake", 32'(wake),    32'h1);
    boundary = 1'b1;
    step();
    chk("pri_mei_pend",  32'(trap_pending), 32'h1);
    chk("pri_mei_cause", trap_cause,        32'h8000_000B);
    step();
    chk("pri_no_irq_trap", 32'(trap_pending), 32'h0);
    step();
    chk("pri_no_irq_hdl",  32'(trap_pending), 32'h0);
    boundary = 1'b0; trap_finish = 1'b1;
    step();
    trap_finish = 1'b0;
    ext_irq = 4'h0;
    repeat (3) step();
    chk("pri_mip_nomei", mip, 32'h0000_0088);
    boundary = 1'b1;
    step();
    chk("pri_msi_cause", trap_cause, 32'h8000_0003);
    finish_trap("pri_msi");
    soft_irq = 1'b0;
    repeat (3) step();
    chk("pri_mip_mti", mip, 32'h0000_0080);
    boundary = 1'b1;
    step();
    chk("pri_mti_pend",  32'(trap_pending), 32'h1);
    chk("pri_mti_cause", trap_cause,        32'h8000_0007);
    finish_trap("pri_mti");

    // ---- Masking ----
    mie = 32'h0; irq_en = 1'b1; boundary = 1'b1;
    repeat (3) step();
    chk("msk_pend0", 32'(trap_pending), 32'h0);
    chk("msk_wake0", 32'(wake),         32'h0);
    mie = 32'h0000_0080; irq_en = 1'b0;
    step();
    chk("msk_wake1", 32'(wake),         32'h1);
    chk("msk_pend1", 32'(trap_pending), 32'h0);
    irq_en = 1'b1;
    step();
    chk("msk_pend2",  32'(trap_pending), 32'h1);
    chk("msk_cause2", trap_cause,        32'h8000_0007);
    finish_trap("msk");

    // ---- Collision: exception beats a pending enabled interrupt ----
    boundary = 1'b1; exc_valid = 1'b1; exc_cause = 5'd3;
    step();
    exc_valid = 1'b0;
    chk("col_pend",  32'(trap_pending), 32'h1);
    chk("col_cause", trap_cause,        32'h0000_0003);
    step();
    chk("col_gap1", 32'(trap_pending), 32'h0);
    step();
    chk("col_gap2", 32'(trap_pending), 32'h0);
    trap_finish = 1'b1;
    step();
    trap_finish = 1'b0;
    chk("col_idle_pend", 32'(trap_pending), 32'h0);
    step();
    chk("col_irq_pend",  32'(trap_pending), 32'h1);
    chk("col_irq_cause", trap_cause,        32'h8000_0007);

    // ---- Reset asserted in the trap_pending cycle ----
    #2;
    rst = 1'b1;
    #1;
    chk("rtr_pend_async",  32'(trap_pending), 32'h0);
    chk("rtr_cause_async", trap_cause,        32'h0);
    timer_irq = 1'b0; boundary = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rtr_state", 32'(dut.state_q),  32'(IDLE));
    chk("rtr_mip",   mip,               32'h0);
    chk("rtr_pend",  32'(trap_pending), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
